// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// access-size codes and default bus widths.
package lsu_pkg;

  localparam int LSU_DATA_W = 16;
  localparam int LSU_ADDR_W = 16;
  localparam int LSU_MEM_AW = 3;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory signals of the load/store unit,
// bundled with a slave view (the unit) and a master view (pipeline + memory).
interface lsu_if #(
  parameter int DATA_W = lsu_pkg::LSU_DATA_W,
  parameter int ADDR_W = lsu_pkg::LSU_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic              req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_Write;
  logic              mem_Read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_write_data, mem_Write, mem_Read
  );

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_write_data, mem_Write, mem_Read
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a loaded byte/halfword, and
// merges a store byte into the current memory word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              addr_lsb,
  input  logic              size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] mem_word,
  input  logic [7:0]        store_byte,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_word
);

  logic [7:0] lane;

  // Little-endian lanes: addr[0]=0 is bits [7:0], addr[0]=1 is bits [15:8].
  always_comb begin
    lane      = addr_lsb ? mem_word[15:8] : mem_word[7:0];
    load_data = mem_word;
    if (size == SZ_BYTE) begin
      if (is_unsigned) begin
        load_data = {{(DATA_W-8){1'b0}}, lane};
      end else begin
        load_data = {{(DATA_W-8){lane[7]}}, lane};
      end
    end
    merged_word = mem_word;
    if (addr_lsb) begin
      merged_word[15:8] = store_byte;
    end else begin
      merged_word[7:0]  = store_byte;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 16-bit word memory without byte enables.
// Optional macro LSU_MISALIGN_TRAP_EN: odd-address halfwords return resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W,
  parameter int ADDR_W = LSU_ADDR_W
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  lsu_state_t        state;
  lsu_state_t        state_next;

  logic              is_store_q;
  logic              size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merged_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              ready;
  logic              resp_valid;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] write_data;
  logic              accept;
  logic              trap_req;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_req = (bus.req_size == SZ_HALF) && bus.req_addr[0];
`else
  assign trap_req = 1'b0;
`endif

  assign accept = bus.req_valid && (state == ST_IDLE);

  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .addr_lsb    (addr_q[0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .mem_word    (bus.mem_read_data),
    .store_byte  (wdata_q[7:0]),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are decoded purely from state so an async reset drops them at once.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_data = '0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          state_next = trap_req ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (is_store_q && (size_q == SZ_HALF)) begin
          mem_write  = 1'b1;
          write_data = wdata_q;
          state_next = ST_RESP;
        end else begin
          mem_read   = 1'b1;
          state_next = is_store_q ? ST_WRITE : ST_RESP;
        end
      end
      ST_WRITE: begin
        mem_write  = 1'b1;
        write_data = merged_q;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, load result and the byte-store merge word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        is_store_q <= bus.req_is_store;
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        rdata_q    <= '0;
        err_q      <= trap_req;
      end
      if ((state == ST_ACCESS) && !is_store_q) begin
        rdata_q <= load_data;
      end
      if ((state == ST_ACCESS) && is_store_q && (size_q == SZ_BYTE)) begin
        merged_q <= merged_word;
      end
    end
  end

  assign bus.req_ready      = ready;
  assign bus.resp_valid     = resp_valid;
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_err       = err_q;
  assign bus.mem_addr       = {1'b0, addr_q[ADDR_W-1:1]};
  assign bus.mem_write_data = write_data;
  assign bus.mem_Write      = mem_write;
  assign bus.mem_Read       = mem_read;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// loads/stores checked against a byte-array memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] mem [8];
  logic        preload_en = 1'b0;
  logic [2:0]  preload_idx = '0;
  logic [15:0] preload_data = '0;

  assign bus.mem_read_data = mem[bus.mem_addr[LSU_MEM_AW-1:0]];

  always @(posedge clk) begin
    if (bus.mem_Write) begin
      mem[bus.mem_addr[LSU_MEM_AW-1:0]] <= bus.mem_write_data;
    end else if (preload_en) begin
      mem[preload_idx] <= preload_data;
    end
  end

  logic [7:0] ref_bytes [16];
  int errors = 0;
  int checks = 0;

  logic        rd_trace [1:8];
  logic        wr_trace [1:8];
  logic [15:0] wd_trace [1:8];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] refLoad(input logic sz, input logic uns, input logic [15:0] addr);
    logic [7:0] b;
    if (sz == SZ_HALF) begin
      return {ref_bytes[{addr[3:1], 1'b1}], ref_bytes[{addr[3:1], 1'b0}]};
    end
    b = ref_bytes[addr[3:0]];
    return uns ? {8'h00, b} : {{8{b[7]}}, b};
  endfunction

  task automatic refStore(input logic sz, input logic [15:0] addr, input logic [15:0] wd);
    if (sz == SZ_HALF) begin
      ref_bytes[{addr[3:1], 1'b0}] = wd[7:0];
      ref_bytes[{addr[3:1], 1'b1}] = wd[15:8];
    end else begin
      ref_bytes[addr[3:0]] = wd[7:0];
    end
  endtask

  function automatic logic isTrap(input logic sz, input logic [15:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == SZ_HALF) && addr[0];
`else
    return 1'b0 && sz && addr[0];
`endif
  endfunction

  // One full request: drive, wait for the response, compare with the model.
  task automatic applyStimulus(input string tag, input logic st, input logic sz, input logic uns,
                               input logic [15:0] addr, input logic [15:0] wd);
    int          lat;
    int          exp_lat;
    int          both_cnt;
    int          strobe_cnt;
    logic [15:0] got_rdata;
    logic        got_err;
    logic        trap;
    logic [15:0] exp_rdata;
    trap      = isTrap(sz, addr);
    exp_lat   = trap ? 1 : ((st && (sz == SZ_BYTE)) ? 3 : 2);
    exp_rdata = (st || trap) ? 16'h0000 : refLoad(sz, uns, addr);
    lat        = -1;
    both_cnt   = 0;
    strobe_cnt = 0;
    got_rdata  = '0;
    got_err    = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rd_trace[i] = 1'b0;
      wr_trace[i] = 1'b0;
      wd_trace[i] = '0;
    end
    @(negedge clk);
    checkOutput({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_is_store = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'($urandom);
    bus.req_size     = 1'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = 16'($urandom);
    bus.req_wdata    = 16'($urandom);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      rd_trace[n] = bus.mem_Read;
      wr_trace[n] = bus.mem_Write;
      wd_trace[n] = bus.mem_write_data;
      if (bus.mem_Read && bus.mem_Write) both_cnt++;
      if (bus.mem_Read || bus.mem_Write) strobe_cnt++;
      if (bus.resp_valid) begin
        lat       = n;
        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_err;
        break;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " rdata"}, {16'd0, got_rdata}, {16'd0, exp_rdata});
    checkOutput({tag, " err"}, {31'd0, got_err}, {31'd0, trap});
    checkOutput({tag, " rd&wr"}, 32'(both_cnt), 32'd0);
    if (trap) checkOutput({tag, " strobes"}, 32'(strobe_cnt), 32'd0);
    @(negedge clk);
    checkOutput({tag, " pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    if (st && !trap) refStore(sz, addr, wd);
    if (st) begin
      checkOutput({tag, " memword"}, {16'd0, mem[addr[3:1]]},
                  {16'd0, ref_bytes[{addr[3:1], 1'b1}], ref_bytes[{addr[3:1], 1'b0}]});
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] b2b_addr [4];
    logic        b2b_sz   [4];
    logic        b2b_uns  [4];
    logic [15:0] b2b_exp  [4];
    int          resp_cnt;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_size     = 1'b0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    // Preload memory and the model with the same random words while in reset.
    preload_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      ref_bytes[2*i]   = w[7:0];
      ref_bytes[2*i+1] = w[15:8];
      @(negedge clk);
      preload_idx  = 3'(i);
      preload_data = w;
      @(posedge clk);
    end
    #1;
    preload_en = 1'b0;
    checkOutput("rst ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("rst rdata", {16'd0, bus.resp_rdata}, 32'd0);
    checkOutput("rst err", {31'd0, bus.resp_err}, 32'd0);
    checkOutput("rst strobes", {30'd0, bus.mem_Write, bus.mem_Read}, 32'd0);
    checkOutput("rst mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst wdata", {16'd0, bus.mem_write_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("SH 80F0@4", 1'b1, SZ_HALF, 1'b0, 16'h0004, 16'h80F0);
    checkOutput("word2 after SH", {16'd0, mem[2]}, 32'h80F0);
    applyStimulus("LH @4", 1'b0, SZ_HALF, 1'b0, 16'h0004, 16'h0000);
    applyStimulus("LB @4", 1'b0, SZ_BYTE, 1'b0, 16'h0004, 16'h0000);
    checkOutput("LB @4 model", {16'd0, refLoad(SZ_BYTE, 1'b0, 16'h0004)}, 32'hFFF0);
    applyStimulus("LBU @5", 1'b0, SZ_BYTE, 1'b1, 16'h0005, 16'h0000);
    applyStimulus("LB @5", 1'b0, SZ_BYTE, 1'b0, 16'h0005, 16'h0000);

    applyStimulus("SB 7A@5", 1'b1, SZ_BYTE, 1'b0, 16'h0005, 16'h127A);
    checkOutput("SB access rd", {31'd0, rd_trace[1]}, 32'd1);
    checkOutput("SB access wr", {31'd0, wr_trace[1]}, 32'd0);
    checkOutput("SB write wr", {31'd0, wr_trace[2]}, 32'd1);
    checkOutput("SB write rd", {31'd0, rd_trace[2]}, 32'd0);
    checkOutput("SB write data", {16'd0, wd_trace[2]}, 32'h7AF0);
    applyStimulus("LH after SB", 1'b0, SZ_HALF, 1'b0, 16'h0004, 16'h0000);

    // Reset in the middle of a byte store's write cycle.
    applyStimulus("SH restore", 1'b1, SZ_HALF, 1'b0, 16'h0004, 16'h80F0);
    @(negedge clk);
    bus.req_is_store = 1'b1;
    bus.req_size     = SZ_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 16'h0005;
    bus.req_wdata    = 16'h007A;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstW access rd", {31'd0, bus.mem_Read}, 32'd1);
    @(negedge clk);
    checkOutput("rstW write wr", {31'd0, bus.mem_Write}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstW wr drop", {31'd0, bus.mem_Write}, 32'd0);
    checkOutput("rstW rd", {31'd0, bus.mem_Read}, 32'd0);
    checkOutput("rstW ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("rstW resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("rstW mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    checkOutput("rstW wdata", {16'd0, bus.mem_write_data}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_cnt++;
    end
    checkOutput("rstW no resp", 32'(resp_cnt), 32'd0);
    checkOutput("rstW word2", {16'd0, mem[2]}, 32'h80F0);

    // Four back-to-back loads with req_valid held high.
    for (int k = 0; k < 4; k++) begin
      b2b_addr[k] = 16'($urandom);
      b2b_sz[k]   = 1'($urandom);
      b2b_uns[k]  = 1'($urandom);
      if (b2b_sz[k] == SZ_HALF) b2b_addr[k][0] = 1'b0;
      b2b_exp[k]  = refLoad(b2b_sz[k], b2b_uns[k], b2b_addr[k]);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b ready c%0d", c), {31'd0, bus.req_ready}, {31'd0, (c % 3) == 0});
      checkOutput($sformatf("b2b resp c%0d", c), {31'd0, bus.resp_valid}, {31'd0, (c % 3) == 2});
      if ((c % 3) == 2) begin
        checkOutput($sformatf("b2b rdata %0d", c / 3), {16'd0, bus.resp_rdata}, {16'd0, b2b_exp[c / 3]});
      end
      if ((c % 3) == 0) begin
        bus.req_is_store = 1'b0;
        bus.req_size     = b2b_sz[c / 3];
        bus.req_unsigned = b2b_uns[c / 3];
        bus.req_addr     = b2b_addr[c / 3];
        bus.req_valid    = 1'b1;
      end
      if (c == 11) bus.req_valid = 1'b0;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    w = mem[1];
    applyStimulus("trap LH@3", 1'b0, SZ_HALF, 1'b0, 16'h0003, 16'h0000);
    applyStimulus("trap SH@3", 1'b1, SZ_HALF, 1'b0, 16'h0003, 16'hBEEF);
    checkOutput("trap word1", {16'd0, mem[1]}, {16'd0, w});
`endif

    for (int r = 0; r < 60; r++) begin
      applyStimulus($sformatf("rand%0d", r), 1'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
